// File: rtl/bitstream_pkg.sv
// bitstream_pkg: shared types, default width and result saturation for the bitstream decoder
// Optional macro BITSTREAM_DECODER_BIPOLAR_EN selects a signed bipolar result (count - N/2).
package bitstream_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;
  // A count of N does not fit in WIDTH bits, so it clamps to the largest code.
  // Callers truncate the result to WIDTH bits, giving two's complement in bipolar mode.
  function automatic logic [31:0] sat_result(input logic [31:0] count, input int width);
    logic [31:0] n, c;
    n = 32'd1 << width;
    c = (count >= n) ? n - 32'd1 : count;
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
    return c - (n >> 1);
`else
    return c;
`endif
  endfunction
endpackage

// File: rtl/ones_counter.sv
// ones_counter: window accumulator of 1s plus sample counter with terminal-count flag
// Ports: clk, n_rst (async active-low), clr (restart window), en (count this cycle), x (sample),
//        acc (ones so far, WIDTH+1 bits), last (current sample is the final one of the window).
module ones_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             en,
  input  logic             x,
  output logic [WIDTH:0]   acc,
  output logic             last
);
  logic [WIDTH-1:0] cnt;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (en) begin
      acc <= acc + (WIDTH+1)'(x);
      cnt <= cnt + 1'b1;
    end
  assign last = en && (cnt == '1);
endmodule

// File: rtl/bitstream_decoder.sv
// bitstream_decoder: counts 1s of a unipolar bitstream over 2^WIDTH cycles and presents the value
// Ports: clk, n_rst (async active-low), x (stream bit), start (begin window), busy (counting),
//        y (result, held while valid), valid/ready (output handshake).
// Optional macro BITSTREAM_DECODER_BIPOLAR_EN makes y signed: count - N/2.
module bitstream_decoder
  import bitstream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             x,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] y,
  output logic             valid,
  input  logic             ready
);
  state_t         state;
  logic           clr, en, last;
  logic [WIDTH:0] acc, total;
  assign en    = state == COUNT;
  assign clr   = start && (state == IDLE || (state == HOLD && valid && ready));
  assign total = acc + (WIDTH+1)'(x);
  ones_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .n_rst(n_rst),
    .clr  (clr),
    .en   (en),
    .x    (x),
    .acc  (acc),
    .last (last)
  );
  // HOLD spends one cycle with valid low while y settles; ready is only honoured once valid is up.
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
      y     <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= COUNT;
          busy  <= 1'b1;
        end
        COUNT: if (last) begin
          state <= HOLD;
          busy  <= 1'b0;
          y     <= WIDTH'(sat_result(32'(total), WIDTH));
        end
        HOLD: if (!valid) valid <= 1'b1;
        else if (ready) begin
          valid <= 1'b0;
          busy  <= start;
          state <= start ? COUNT : IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_bitstream_decoder.sv
// tb_bitstream_decoder: randomized self-checking bench for bitstream_decoder at WIDTH=4
module tb_bitstream_decoder;
  logic       clk = 1'b0;
  logic       n_rst, x, start, ready, busy, valid;
  logic [3:0] y;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] last_y;

  bitstream_decoder #(.WIDTH(4)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .x    (x),
    .start(start),
    .busy (busy),
    .y    (y),
    .valid(valid),
    .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_y(input int c);
    int v;
    v = (c >= 16) ? 15 : c;
`ifdef BITSTREAM_DECODER_BIPOLAR_EN
    v = v - 8;
`endif
    return 4'(v);
  endfunction

  // Called at a negedge; issues start (with ready, so it also works back-to-back from HOLD).
  // mode: 0 zeros, 1 ones, 2 alternating 1,0, 3 random.
  task automatic window(input int mode);
    int cnt, b;
    start = 1'b1;
    ready = 1'b1;
    x = (mode == 2) ? 1'b1 : 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    ready = 1'b0;
    chk("busy_go", busy, 1);
    chk("valid_go", valid, 0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      b = (mode == 0) ? 0 : (mode == 1) ? 1 : (mode == 2) ? ((i % 2 == 0) ? 1 : 0) : int'($urandom_range(0, 1));
      x = 1'(b);
      cnt += b;
      start = 1'($urandom);
      ready = 1'($urandom);
      @(negedge clk);
      if (i < 15) chk("busy_cnt", busy, 1);
    end
    start = 1'b0;
    ready = 1'b0;
    x = 1'($urandom);
    chk("busy_end", busy, 0);
    chk("valid_gap", valid, 0);
    @(negedge clk);
    chk("valid", valid, 1);
    chk("y", y, model_y(cnt));
    last_y = model_y(cnt);
  endtask

  task automatic hold_release();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      x = 1'($urandom);
      @(negedge clk);
      chk("hold_valid", valid, 1);
      chk("hold_y", y, last_y);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("rel_valid", valid, 0);
    chk("rel_busy", busy, 0);
    @(negedge clk);
    chk("idle_valid", valid, 0);
    chk("idle_y", y, last_y);
  endtask

  initial begin
    n_rst = 1'b0;
    x = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_y", y, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    n_rst = 1'b1;
    @(negedge clk);
    window(0);
    hold_release();
    window(1);
    window(2);
    hold_release();
    repeat (6) window(3);
    hold_release();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = 1'b1;
    repeat (7) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("abort_y", y, 0);
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    window(3);
    hold_release();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
